// File: rtl/datapath_pkg.sv
// Shared codes for the multi-cycle LEGv8-style datapath: ALU op codes,
// result-source codes, control FSM states and STAT bit positions.
package datapath_pkg;

    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_XOR  = 3'b011;
    localparam logic [2:0] ALU_SHL  = 3'b100;
    localparam logic [2:0] ALU_SHR  = 3'b101;
    localparam logic [2:0] ALU_PASS = 3'b110;
    localparam logic [2:0] ALU_NOR  = 3'b111;

    localparam logic [1:0] SRC_ALU = 2'b00;
    localparam logic [1:0] SRC_B   = 2'b01;
    localparam logic [1:0] SRC_LD  = 2'b10;
    localparam logic [1:0] SRC_ST  = 2'b11;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        EXEC     = 2'b01,
        MEM_REQ  = 2'b10,
        MEM_WAIT = 2'b11
    } state_t;

    localparam int STAT_Z = 0;
    localparam int STAT_N = 1;
    localparam int STAT_C = 2;
    localparam int STAT_V = 3;

endpackage

// File: rtl/datapath_mc_regfile.sv
// Register file: two operand read ports plus a narrow debug read port,
// one synchronous write port; the top register is hardwired to zero.
module regfile_param #(
    parameter int DATA_W = 64,
    parameter int REG_N  = 32,
    parameter int DBG_W  = 16,
    parameter int RA_W   = $clog2(REG_N)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [RA_W-1:0]   ra_a,
    input  logic [RA_W-1:0]   ra_b,
    input  logic [RA_W-1:0]   ra_dbg,
    output logic [DATA_W-1:0] rd_a,
    output logic [DATA_W-1:0] rd_b,
    output logic [DBG_W-1:0]  rd_dbg,
    input  logic              we,
    input  logic [RA_W-1:0]   wa,
    input  logic [DATA_W-1:0] wd
);

    localparam logic [RA_W-1:0] ZR = RA_W'(REG_N - 1);

    logic [DATA_W-1:0] regs_q [REG_N];
    logic [DATA_W-1:0] regs_d [REG_N];

    always_comb begin
        regs_d = regs_q;
        if (we && (wa != ZR)) begin
            regs_d[wa] = wd;
        end
        regs_d[REG_N-1] = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_N; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // No write-to-read bypass: a same-cycle read sees the old contents.
    assign rd_a   = (ra_a == ZR) ? '0 : regs_q[ra_a];
    assign rd_b   = (ra_b == ZR) ? '0 : regs_q[ra_b];
    assign rd_dbg = (ra_dbg == ZR) ? '0 : regs_q[ra_dbg][DBG_W-1:0];

endmodule

// File: rtl/datapath_mc.sv
// Multi-cycle datapath: latches one micro-op per handshake, runs it through
// the ALU and either writes back directly or drives a handshaked memory port.
module datapath_mc
    import datapath_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int REG_N  = 32,
    parameter int ADDR_W = 8,
    parameter int DBG_W  = 16,
    localparam int RA_W  = $clog2(REG_N)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [RA_W-1:0]   SA,
    input  logic [RA_W-1:0]   SB,
    input  logic [RA_W-1:0]   DA,
    input  logic              WR,
    input  logic [4:0]        FS,
    input  logic              C0,
    input  logic [DATA_W-1:0] K,
    input  logic              M,
    input  logic [1:0]        DSEL,
    output logic [3:0]        STAT,
    output logic              done,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic [RA_W-1:0]   dbg_sel,
    output logic [DBG_W-1:0]  dbg_data
);

    localparam int SH_W = $clog2(DATA_W);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d, sb_q, sb_d;
    logic [RA_W-1:0]   da_q, da_d;
    logic              wr_q, wr_d, c0_q, c0_d;
    logic [4:0]        fs_q, fs_d;
    logic [1:0]        dsel_q, dsel_d;
    logic [3:0]        stat_q, stat_d;

    logic [DATA_W-1:0] rd_a, rd_b, rf_wd;
    logic              rf_we;

    logic [DATA_W-1:0] op_a, op_b, alu_f;
    logic [DATA_W:0]   sum;
    logic [3:0]        alu_flags;

    regfile_param #(
        .DATA_W(DATA_W),
        .REG_N (REG_N),
        .DBG_W (DBG_W),
        .RA_W  (RA_W)
    ) u_rf (
        .clk   (CLK),
        .rst_n (RST),
        .ra_a  (SA),
        .ra_b  (SB),
        .ra_dbg(dbg_sel),
        .rd_a  (rd_a),
        .rd_b  (rd_b),
        .rd_dbg(dbg_data),
        .we    (rf_we),
        .wa    (da_q),
        .wd    (rf_wd)
    );

    // ALU works only on latched operands, so its result (and hence the
    // memory address) stays stable for as long as a request is pending.
    always_comb begin
        op_a = fs_q[1] ? ~a_q : a_q;
        op_b = fs_q[0] ? ~b_q : b_q;
        sum  = {1'b0, op_a} + {1'b0, op_b} + {{DATA_W{1'b0}}, c0_q};
        alu_flags = '0;
        case (fs_q[4:2])
            ALU_AND:  alu_f = op_a & op_b;
            ALU_OR:   alu_f = op_a | op_b;
            ALU_ADD:  alu_f = sum[DATA_W-1:0];
            ALU_XOR:  alu_f = op_a ^ op_b;
            ALU_SHL:  alu_f = op_a << op_b[SH_W-1:0];
            ALU_SHR:  alu_f = op_a >> op_b[SH_W-1:0];
            ALU_PASS: alu_f = op_a;
            default:  alu_f = ~(op_a | op_b);
        endcase
        if (fs_q[4:2] == ALU_ADD) begin
            alu_flags[STAT_C] = sum[DATA_W];
            alu_flags[STAT_V] = (op_a[DATA_W-1] == op_b[DATA_W-1]) &&
                                (alu_f[DATA_W-1] != op_a[DATA_W-1]);
        end
        alu_flags[STAT_N] = alu_f[DATA_W-1];
        alu_flags[STAT_Z] = (alu_f == '0);
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sb_d     = sb_q;
        da_d     = da_q;
        wr_d     = wr_q;
        fs_d     = fs_q;
        c0_d     = c0_q;
        dsel_d   = dsel_q;
        stat_d   = stat_q;
        in_ready = 1'b0;
        done     = 1'b0;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        rf_we    = 1'b0;
        rf_wd    = alu_f;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_d     = rd_a;
                    b_d     = M ? K : rd_b;
                    sb_d    = rd_b;
                    da_d    = DA;
                    wr_d    = WR;
                    fs_d    = FS;
                    c0_d    = C0;
                    dsel_d  = DSEL;
                    state_d = EXEC;
                end
            end
            EXEC, MEM_REQ: begin
                if ((state_q == EXEC) && !dsel_q[1]) begin
                    rf_we   = wr_q;
                    rf_wd   = (dsel_q == SRC_B) ? sb_q : alu_f;
                    done    = 1'b1;
                    state_d = IDLE;
                    if (dsel_q == SRC_ALU) begin
                        stat_d = alu_flags;
                    end
                end else begin
                    mem_req = 1'b1;
                    mem_we  = (dsel_q == SRC_ST);
                    if (!mem_gnt) begin
                        state_d = MEM_REQ;
                    end else if (dsel_q == SRC_ST) begin
                        done    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = MEM_WAIT;
                    end
                end
            end
            MEM_WAIT: begin
                if (mem_rvalid) begin
                    rf_we   = wr_q;
                    rf_wd   = mem_rdata;
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sb_q    <= '0;
            da_q    <= '0;
            wr_q    <= 1'b0;
            fs_q    <= '0;
            c0_q    <= 1'b0;
            dsel_q  <= '0;
            stat_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sb_q    <= sb_d;
            da_q    <= da_d;
            wr_q    <= wr_d;
            fs_q    <= fs_d;
            c0_q    <= c0_d;
            dsel_q  <= dsel_d;
            stat_q  <= stat_d;
        end
    end

    assign STAT      = stat_q;
    assign mem_addr  = alu_f[ADDR_W-1:0];
    assign mem_wdata = sb_q;

endmodule

// File: tb/tb_datapath_mc.sv
// Directed bench for datapath_mc: a table of ALU/pass micro-ops followed by
// hand-written store, load, reset-abort and back-to-back handshake sequences.
module tb_datapath_mc;

    localparam logic [4:0] F_ADD  = 5'b01000;
    localparam logic [4:0] F_SUB  = 5'b01001;
    localparam logic [4:0] F_AND  = 5'b00000;
    localparam logic [4:0] F_OR   = 5'b00100;
    localparam logic [4:0] F_XOR  = 5'b01100;
    localparam logic [4:0] F_SHL  = 5'b10000;
    localparam logic [4:0] F_SHR  = 5'b10100;
    localparam logic [4:0] F_NPA  = 5'b11010;
    localparam logic [4:0] F_NOR  = 5'b11100;

    typedef struct {
        logic [4:0]  sa, sb, da;
        logic        wr;
        logic [4:0]  fs;
        logic        c0;
        logic [63:0] k;
        logic        m;
        logic [1:0]  dsel;
        logic [4:0]  chk;
        logic [15:0] exp_dbg;
        logic [3:0]  exp_stat;
    } vec_t;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        in_valid, in_ready;
    logic [4:0]  SA, SB, DA, dbg_sel;
    logic        WR, C0, M;
    logic [4:0]  FS;
    logic [63:0] K;
    logic [1:0]  DSEL;
    logic [3:0]  STAT;
    logic        done, mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [7:0]  mem_addr;
    logic [63:0] mem_wdata, mem_rdata;
    logic [15:0] dbg_data;

    int checks = 0;
    int errors = 0;
    vec_t vecs[17];

    always #5 CLK = ~CLK;

    datapath_mc dut (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready),
        .SA(SA), .SB(SB), .DA(DA), .WR(WR), .FS(FS), .C0(C0), .K(K), .M(M),
        .DSEL(DSEL), .STAT(STAT), .done(done), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .dbg_sel(dbg_sel), .dbg_data(dbg_data)
    );

    function automatic vec_t mk(input logic [4:0] sa, input logic [4:0] sb,
                                input logic [4:0] da, input logic wr,
                                input logic [4:0] fs, input logic c0,
                                input logic [63:0] k, input logic m,
                                input logic [1:0] dsel, input logic [4:0] chk,
                                input logic [15:0] exp_dbg, input logic [3:0] exp_stat);
        vec_t v;
        v.sa = sa; v.sb = sb; v.da = da; v.wr = wr; v.fs = fs; v.c0 = c0;
        v.k = k; v.m = m; v.dsel = dsel; v.chk = chk;
        v.exp_dbg = exp_dbg; v.exp_stat = exp_stat;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Offers a micro-op and returns at the falling edge just after it is accepted.
    task automatic startOp(input vec_t v);
        int n;
        @(negedge CLK);
        SA = v.sa; SB = v.sb; DA = v.da; WR = v.wr; FS = v.fs; C0 = v.c0;
        K = v.k; M = v.m; DSEL = v.dsel;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge CLK);
            n++;
        end
        @(negedge CLK);
        in_valid = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v, output int lat);
        startOp(v);
        lat = 1;
        while (!done && lat < 50) begin
            @(negedge CLK);
            lat++;
        end
    endtask

    task automatic loadSeq(input logic [4:0] da, input logic [15:0] exp_dbg, input string tag);
        startOp(mk(31, 0, da, 1, F_ADD, 0, 64'h10, 1, 2'b10, 0, 0, 0));
        checkOutput({tag, "_req"}, mem_req, 1);
        checkOutput({tag, "_we"}, mem_we, 0);
        checkOutput({tag, "_addr"}, mem_addr, 8'h10);
        mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 64'h77;
        #1 checkOutput({tag, "_early_rvalid_done"}, done, 0);
        @(negedge CLK);
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        #1 checkOutput({tag, "_wait_req"}, mem_req, 0);
        checkOutput({tag, "_wait_done"}, done, 0);
        @(negedge CLK);
        mem_rvalid = 1'b1; mem_rdata = 64'hAB;
        #1 checkOutput({tag, "_done"}, done, 1);
        @(negedge CLK);
        mem_rvalid = 1'b0;
        dbg_sel = da;
        #1 checkOutput({tag, "_dbg"}, dbg_data, exp_dbg);
        checkOutput({tag, "_stat_hold"}, STAT, 4'b0101);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat, acc, dn;
        in_valid = 0; SA = 0; SB = 0; DA = 0; WR = 0; FS = 0; C0 = 0; K = 0;
        M = 0; DSEL = 0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0; dbg_sel = 0;

        vecs[0]  = mk(31, 0,  1, 1, F_ADD, 0, 64'h5,  1, 2'b00,  1, 16'h0005, 4'b0000);
        vecs[1]  = mk( 1, 0,  1, 1, F_SUB, 1, 64'h5,  1, 2'b00,  1, 16'h0000, 4'b0101);
        vecs[2]  = mk(31, 0,  2, 1, F_ADD, 0, 64'h7FFF_FFFF_FFFF_FFFF, 1, 2'b00, 2, 16'hFFFF, 4'b0000);
        vecs[3]  = mk( 2, 0,  3, 1, F_ADD, 0, 64'h1,  1, 2'b00,  3, 16'h0000, 4'b1010);
        vecs[4]  = mk( 3, 0,  4, 1, F_SHR, 0, 64'd48, 1, 2'b00,  4, 16'h8000, 4'b0000);
        vecs[5]  = mk(31, 0,  1, 1, F_ADD, 0, 64'hAB, 1, 2'b00,  1, 16'h00AB, 4'b0000);
        vecs[6]  = mk( 1, 0,  6, 1, F_AND, 0, 64'h0F, 1, 2'b00,  6, 16'h000B, 4'b0000);
        vecs[7]  = mk( 1, 0,  6, 1, F_OR,  0, 64'h100, 1, 2'b00, 6, 16'h01AB, 4'b0000);
        vecs[8]  = mk( 1, 0,  7, 1, F_XOR, 0, 64'hFF, 1, 2'b00,  7, 16'h0054, 4'b0000);
        vecs[9]  = mk( 1, 0,  8, 1, F_SHL, 0, 64'h4,  1, 2'b00,  8, 16'h0AB0, 4'b0000);
        vecs[10] = mk(31, 0, 12, 1, F_NPA, 0, 64'h0,  1, 2'b00, 12, 16'hFFFF, 4'b0010);
        vecs[11] = mk(31, 0, 13, 1, F_NOR, 0, 64'h0,  1, 2'b00, 13, 16'hFFFF, 4'b0010);
        vecs[12] = mk(31, 1,  9, 1, F_ADD, 0, 64'h1234, 1, 2'b01, 9, 16'h00AB, 4'b0010);
        vecs[13] = mk( 1, 7, 10, 1, F_ADD, 0, 64'h0,  0, 2'b00, 10, 16'h00FF, 4'b0000);
        vecs[14] = mk(31, 0, 31, 1, F_ADD, 0, 64'h55, 1, 2'b00, 31, 16'h0000, 4'b0000);
        vecs[15] = mk(31, 0,  1, 0, F_ADD, 0, 64'h99, 1, 2'b00,  1, 16'h00AB, 4'b0000);
        vecs[16] = mk(12, 0, 14, 1, F_ADD, 0, 64'h1,  1, 2'b00, 14, 16'h0000, 4'b0101);

        #2 RST = 1'b0;
        repeat (2) @(negedge CLK);
        checkOutput("rst_mem_req", mem_req, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_stat", STAT, 0);
        RST = 1'b1;
        @(negedge CLK);
        checkOutput("rst_in_ready", in_ready, 1);
        checkOutput("rst_dbg_r0", dbg_data, 0);

        for (int i = 0; i < 17; i++) begin
            applyStimulus(vecs[i], lat);
            checkOutput($sformatf("v%0d_latency", i), lat, 1);
            @(negedge CLK);
            dbg_sel = vecs[i].chk;
            #1 checkOutput($sformatf("v%0d_dbg", i), dbg_data, vecs[i].exp_dbg);
            checkOutput($sformatf("v%0d_stat", i), STAT, vecs[i].exp_stat);
        end

        // Store R1 to 0x10 with grant withheld for three cycles.
        startOp(mk(31, 1, 0, 0, F_ADD, 0, 64'h10, 1, 2'b11, 0, 0, 0));
        for (int c = 1; c <= 4; c++) begin
            checkOutput($sformatf("st_c%0d_req", c), mem_req, 1);
            checkOutput($sformatf("st_c%0d_we", c), mem_we, 1);
            checkOutput($sformatf("st_c%0d_addr", c), mem_addr, 8'h10);
            checkOutput($sformatf("st_c%0d_wdata", c), mem_wdata, 64'hAB);
            if (c < 4) begin
                checkOutput($sformatf("st_c%0d_done", c), done, 0);
                @(negedge CLK);
            end else begin
                mem_gnt = 1'b1;
                #1 checkOutput("st_done", done, 1);
            end
        end
        @(negedge CLK);
        mem_gnt = 1'b0;
        #1 checkOutput("st_after_req", mem_req, 0);
        checkOutput("st_after_ready", in_ready, 1);

        loadSeq(5'd2, 16'h00AB, "ld_r2");
        loadSeq(5'd31, 16'h0000, "ld_r31");

        // Reset while a load is waiting for its data.
        startOp(mk(31, 0, 5, 1, F_ADD, 0, 64'h10, 1, 2'b10, 0, 0, 0));
        mem_gnt = 1'b1;
        @(negedge CLK);
        mem_gnt = 1'b0;
        RST = 1'b0;
        dbg_sel = 5'd1;
        #1 checkOutput("abort_req", mem_req, 0);
        checkOutput("abort_done", done, 0);
        checkOutput("abort_stat", STAT, 0);
        checkOutput("abort_r1_cleared", dbg_data, 0);
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        checkOutput("abort_ready", in_ready, 1);
        mem_rvalid = 1'b1; mem_rdata = 64'h33;
        #1 checkOutput("abort_late_rvalid_done", done, 0);
        @(negedge CLK);
        mem_rvalid = 1'b0;
        dbg_sel = 5'd5;
        #1 checkOutput("abort_r5", dbg_data, 0);

        // Continuous offer: ADD R20 = R20 + 1 must be taken every other cycle.
        @(negedge CLK);
        SA = 5'd20; SB = 0; DA = 5'd20; WR = 1; FS = F_ADD; C0 = 0; K = 64'h1;
        M = 1; DSEL = 2'b00;
        in_valid = 1'b1;
        acc = 0;
        dn = 0;
        for (int k = 0; k < 10; k++) begin
            #1 checkOutput($sformatf("thr_ready_%0d", k), in_ready, (k % 2 == 0) ? 1 : 0);
            if (in_ready && in_valid) acc++;
            if (done) dn++;
            if (k == 9) in_valid = 1'b0;
            @(negedge CLK);
        end
        checkOutput("thr_accepts", acc, 5);
        checkOutput("thr_dones", dn, 5);
        dbg_sel = 5'd20;
        #1 checkOutput("thr_r20", dbg_data, 16'h0005);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/datapath_mc.md
# datapath_mc

Parametrised multi-cycle LEGv8-style datapath: register file, operand mux, ALU and a handshaked data-memory port. It replaces fixed-width tri-state bus steering with a muxed write-back path and a small control FSM, so the memory may take any number of cycles. It sits between the instruction-level control unit, which issues one micro-op at a time over a valid/ready handshake, and the data RAM.

## Interface
- DATA_W, 64: datapath width. Must be at least 8 and a power of 2.
- REG_N, 32: register count; register REG_N-1 is hardwired zero (XZR). Must be a power of 2 and at least 4.
- ADDR_W, 8: memory address width; must be ≤ DATA_W.
- DBG_W, 16: width of the debug read port.
- RA_W: clog2(REG_N), derived.

Ports:
- CLK  in  1  clock; all state on rising edge.
- RST  in  1  reset, asynchronous, active-low.
- in_valid  in  1  micro-op offered.
- in_ready  out  1  block accepts the micro-op.
- SA, SB, DA  in  RA_W  A-source, B-source and destination register.
- WR  in  1  write-back enable.
- FS  in  5  ALU function: FS[4:2] op, FS[1] invert A, FS[0] invert B.
- C0  in  1  ADD carry-in.
- K  in  DATA_W  constant operand.
- M  in  1  B-operand select: 1 selects K, 0 selects R[SB].
- DSEL  in  2  result source: 00 ALU, 01 R[SB] pass, 10 load, 11 store.
- STAT  out  4  {V,C,N,Z} of the last ALU-sourced op.
- done  out  1  one-cycle pulse on micro-op completion.
- mem_req, mem_we  out  1  memory request and write flag.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  store data.
- mem_gnt  in  1  request accepted.
- mem_rvalid  in  1  load data valid.
- mem_rdata  in  DATA_W  load data.
- dbg_sel  in  RA_W  debug register select.
- dbg_data  out  DBG_W  low DBG_W bits of R[dbg_sel], combinational.

## Operation
- ALU ops, selected by FS[4:2]:
  - 000 AND, 001 OR, 010 ADD, 011 XOR, 100 SHL, 101 SHR (logical), 110 pass A, 111 NOR.
  - Operand inversions are applied before the op. SUB is FS=01001 with C0=1.
  - Shift amount is B[clog2(DATA_W)-1:0].
- STAT:
  - Z = (F==0), N = F[DATA_W-1].
  - C and V are valid for ADD only; they are 0 otherwise.
  - STAT updates only on DSEL=00 completion and holds otherwise.
- FSM states: IDLE, EXEC, MEM_REQ, MEM_WAIT.
  - IDLE: in_ready=1. When in_valid=1, latch R[SA], the B operand (muxed by M), R[SB], DA, WR, FS, C0 and DSEL, then go to EXEC.
  - EXEC, DSEL 00/01: write the result to DA if WR=1, pulse done, go to IDLE.
  - EXEC, DSEL 10/11: assert mem_req with mem_addr=F[ADDR_W-1:0] and mem_wdata=latched R[SB]; mem_we=1 for store. If mem_gnt=1 this cycle, follow the MEM_REQ rule below. Otherwise go to MEM_REQ.
  - MEM_REQ: hold mem_req and all mem outputs stable until mem_gnt=1. On grant, a store pulses done and goes to IDLE; a load goes to MEM_WAIT.
  - MEM_WAIT: when mem_rvalid=1, write mem_rdata to DA if WR=1, pulse done, go to IDLE. mem_rvalid is ignored in every other state.
- Writes to REG_N-1 are discarded, and reads of REG_N-1 return 0.
- A write and a read of the same register in the same cycle: the read returns the old value (no bypass); the next micro-op sees the new value.
- Arithmetic wraps modulo 2^DATA_W.

## Timing
- Reset (RST=0, asynchronous):
  - FSM goes to IDLE; all registers, STAT and latched operands are cleared to 0.
  - mem_req=0, mem_we=0, done=0, in_ready=1 once RST=1.
  - Reset mid-transaction abandons the request; a late mem_rvalid is ignored.
- Latency from the accept edge to done:
  - ALU or pass: 1 cycle.
  - Store: 1 cycle + grant wait.
  - Load: ≥2 cycles.
- The write-back is visible to the next accepted micro-op.
- Maximum throughput is one micro-op per 2 cycles. in_ready=0 in every state except IDLE.
- The memory must not assert mem_rvalid in the same cycle as mem_gnt for the same load. If it does, that rvalid is ignored.

## Structure
- Package datapath_pkg holds:
  - FS op codes (ALU_AND ... ALU_NOR)
  - DSEL codes (SRC_ALU, SRC_B, SRC_LD, SRC_ST)
  - FSM state enum
  - STAT bit indices
- One sub-module, regfile_param: REG_N×DATA_W, two asynchronous read ports, one synchronous write port, async active-low clear, top register hardwired to zero.
- The ALU is combinational logic inside datapath_mc.

## Test plan
- Reset with RST=0 mid-MEM_WAIT → mem_req=0, state IDLE, all registers 0; a subsequent mem_rvalid writes nothing.
- Load R1 via ALU op with K=5, M=1, FS=ADD, SA=31, DA=1. Then SUB R1−K=5 → R[DA]=0, STAT={0,1,0,1}, done exactly 1 cycle after accept.
- ADD 0x7FFF…FFFF + 1 → result 0x8000…0000, STAT V=1 N=1 C=0 Z=0.
- Store R1=0xAB at address 0x10 with mem_gnt delayed 3 cycles → mem_req, mem_addr and mem_wdata stay stable for 4 cycles, then done.
- Load from address 0x10 with rvalid 2 cycles after grant, DA=2 → R2=0xAB, dbg_data=0x00AB. Then repeat with DA=31 → register 31 still reads 0.
- Hold in_valid=1 continuously → in_ready toggles, and exactly one micro-op is accepted per completed done.
